shiftright_pipe: RTL and testbench

Three-stage pipelined 64-bit right shifter with a valid/ready handshake. It is the right-shift counterpart of the combinational left barrel shifter in the lane ALU datapath. The shift is split across registered stages so it meets timing at core clock. It carries a per-operation tag, typically the lane or thread id, so results can be written back out of the issue path.

---
 rtl/shiftright_pipe.sv | 161 ++++++++++++++++
 tb/tb_shiftright_pipe.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shiftright_pipe.sv
// ---------------------------------------------------------------------------
// shiftright_pipe
//
// Three-stage pipelined right shifter with a valid/ready handshake. It is the
// right-shift partner of the lane ALU's combinational left barrel shifter.
// The shift distance is consumed two bits per stage:
//   S1 applies shift_amount[1:0] (1, 2), S2 applies [3:2] (4, 8),
//   S3 applies [5:4] (16, 32).
// A per-operation tag rides along so results can be written back out of the
// issue path. Results leave strictly in order.
//
// Optional feature macro: SHIFTRIGHT_ARITH_EN
//   defined   : arith selects sign fill (fill = arith & in0[WIDTH-1]).
//   undefined : arith is ignored, every shift is logical, no fill register.
//
// Ports:
//   clk          core clock, rising edge
//   rst          asynchronous active-high reset
//   flush        synchronous clear of all stage valid bits
//   in_valid     operand presented
//   in_ready     operand can be accepted this cycle
//   in0          value to shift (WIDTH bits)
//   shift_amount shift distance 0..63
//   arith        1 = arithmetic (sign fill), 0 = logical (zero fill)
//   in_tag       opaque tag carried with the operand
//   out_valid    result presented
//   out_ready    consumer accepts the result
//   lsr          shifted result
//   out_tag      tag of the presented result
//   busy         any stage holds a valid operation
// ---------------------------------------------------------------------------
module shiftright_pipe #(
    parameter int WIDTH = 64,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in0,
    input  logic [5:0]       shift_amount,
    input  logic             arith,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] lsr,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    // Right shift by k with the vacated MSBs set to f. For k >= WIDTH the
    // data term goes to zero and the mask goes to all ones, so the result
    // saturates to all-fill across stages without special casing.
    function automatic logic [WIDTH-1:0] fill_shift(
        input logic [WIDTH-1:0] d,
        input logic [5:0]       k,
        input logic             f
    );
        logic [WIDTH-1:0] ones;
        ones = {WIDTH{1'b1}};
        return (d >> k) | ({WIDTH{f}} & ~(ones >> k));
    endfunction

    logic             v1, v2, v3;
    logic [WIDTH-1:0] d1, d2, d3;
    logic [3:0]       a1;
    logic [1:0]       a2;
    logic [TAG_W-1:0] t1, t2, t3;
    logic             in_fill, s1_fill, s2_fill;
    logic             adv1, adv2, adv3;
    logic             load1, load2, load3;
    logic             accept;

    // Backpressure ripples combinationally from out_ready up to in_ready;
    // a stage may load whenever it is empty or its content is moving on.
    assign adv3     = v3 & out_ready;
    assign load3    = ~v3 | adv3;
    assign adv2     = v2 & load3;
    assign load2    = ~v2 | adv2;
    assign adv1     = v1 & load2;
    assign load1    = ~v1 | adv1;
    assign in_ready = load1 & ~flush;
    assign accept   = in_valid & in_ready;

`ifdef SHIFTRIGHT_ARITH_EN
    assign in_fill = arith & in0[WIDTH-1];

    // The fill bit is decided once at acceptance and travels with the data,
    // so every later stage fills vacated MSBs with the original sign.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_fill <= 1'b0;
            s2_fill <= 1'b0;
        end else begin
            if (accept) s1_fill <= in_fill;
            if (adv1)   s2_fill <= s1_fill;
        end
    end
`else
    logic unused_arith;
    assign unused_arith = arith;
    assign in_fill      = 1'b0;
    assign s1_fill      = 1'b0;
    assign s2_fill      = 1'b0;
`endif

    // Stage valid bits: flush wins over every advance; a vacated stage that
    // is not refilled takes the upstream (possibly zero) valid bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else if (flush) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            if (load1) v1 <= in_valid;
            if (load2) v2 <= v1;
            if (load3) v3 <= v2;
        end
    end

    // Payload registers only load when a real operation moves in, so a
    // stalled stage keeps its data, remaining amount and tag untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d1 <= '0;
            d2 <= '0;
            d3 <= '0;
            a1 <= '0;
            a2 <= '0;
            t1 <= '0;
            t2 <= '0;
            t3 <= '0;
        end else begin
            if (accept) begin
                d1 <= fill_shift(in0, {4'b0000, shift_amount[1:0]}, in_fill);
                a1 <= shift_amount[5:2];
                t1 <= in_tag;
            end
            if (adv1) begin
                d2 <= fill_shift(d1, {2'b00, a1[1:0], 2'b00}, s1_fill);
                a2 <= a1[3:2];
                t2 <= t1;
            end
            if (adv2) begin
                d3 <= fill_shift(d2, {a2, 4'b0000}, s2_fill);
                t3 <= t2;
            end
        end
    end

    assign out_valid = v3;
    assign lsr       = d3;
    assign out_tag   = t3;
    assign busy      = v1 | v2 | v3;

endmodule

// File: tb/tb_shiftright_pipe.sv
// ---------------------------------------------------------------------------
// tb_shiftright_pipe
//
// Self-checking bench for shiftright_pipe (WIDTH=64, TAG_W=4). A table of
// directed vectors checks values and latency, hand-written sequences cover
// backpressure, flush and asynchronous reset, and a randomized phase is
// checked against a bit-level reference model through an in-order
// scoreboard. Honours SHIFTRIGHT_ARITH_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_shiftright_pipe;

    localparam int WIDTH = 64;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in0;
    logic [5:0]       shift_amount;
    logic             arith;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] lsr;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;
    int retired  = 0;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [TAG_W-1:0] tag;
    } exp_t;

    typedef struct {
        logic [63:0] in0;
        logic [5:0]  amt;
        logic        arith;
        logic [3:0]  tag;
        logic [63:0] exp;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[12];

    shiftright_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in0          (in0),
        .shift_amount (shift_amount),
        .arith        (arith),
        .in_tag       (in_tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .lsr          (lsr),
        .out_tag      (out_tag),
        .busy         (busy)
    );

    // Free-running core clock, 10 time-unit period.
    always #5 clk = ~clk;

    // Reference: each result bit i takes source bit i+amt, or the fill bit
    // once that source lies beyond the MSB.
    function automatic logic [WIDTH-1:0] refShift(
        input logic [WIDTH-1:0] v,
        input logic [5:0]       amt,
        input logic             a
    );
        logic [WIDTH-1:0] r;
        logic             f;
`ifdef SHIFTRIGHT_ARITH_EN
        f = a & v[WIDTH-1];
`else
        f = 1'b0 & a;
`endif
        for (int i = 0; i < WIDTH; i++) begin
            if (i + int'(amt) < WIDTH) r[i] = v[i + int'(amt)];
            else                       r[i] = f;
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [63:0] v, input logic [5:0] amt,
                                 input logic a, input logic [3:0] tag,
                                 input logic valid);
        in0          = v;
        shift_amount = amt;
        arith        = a;
        in_tag       = tag;
        in_valid     = valid;
    endtask

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: sampled on the falling edge where all handshake signals
    // are settled. Retirement is checked before flush clears the model, so
    // a result retiring under flush still counts as delivered.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_checks++;
                retired++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL stale_result: got lsr=%h tag=%0d, required no result",
                             lsr, out_tag);
                end else begin
                    e = sb.pop_front();
                    if (lsr !== e.data || out_tag !== e.tag) begin
                        n_fail++;
                        $display("[TB] FAIL scoreboard: got lsr=%h tag=%0d, required lsr=%h tag=%0d",
                                 lsr, out_tag, e.data, e.tag);
                    end
                end
            end
            if (flush) sb.delete();
            if (in_valid && in_ready)
                sb.push_back('{refShift(in0, shift_amount, arith), in_tag});
        end
    end

    // One isolated operation: accept it, then count the edges until the
    // result shows up. Accept at the edge ending cycle t and valid in cycle
    // t+3 means exactly two further edges.
    task automatic runVector(input int idx);
        int n;
        out_ready = 1'b1;
        applyStimulus(vecs[idx].in0, vecs[idx].amt, vecs[idx].arith, vecs[idx].tag, 1'b1);
        n = 0;
        while (!in_ready && n < 20) begin
            waitCycle();
            n++;
        end
        waitCycle();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            waitCycle();
            n++;
        end
        checkOutput($sformatf("vec%0d_latency", idx), 64'(n), 64'd2);
        checkOutput($sformatf("vec%0d_lsr", idx), lsr, vecs[idx].exp);
        checkOutput($sformatf("vec%0d_tag", idx), 64'(out_tag), 64'(vecs[idx].tag));
        waitCycle();
    endtask

    initial begin
        int n;
        int seen;
        int idx;
        int base;
        logic acc;

        vecs[0]  = '{64'h8000_0000_0000_00F0, 6'd4,  1'b0, 4'd3,  64'h0800_0000_0000_000F};
        vecs[3]  = '{64'h8000_0000_0000_0001, 6'd63, 1'b0, 4'd8,  64'h0000_0000_0000_0001};
        vecs[4]  = '{64'h8000_0000_0000_0001, 6'd0,  1'b1, 4'd9,  64'h8000_0000_0000_0001};
        vecs[5]  = '{64'hDEAD_BEEF_1234_5678, 6'd32, 1'b0, 4'd10, 64'h0000_0000_DEAD_BEEF};
        vecs[7]  = '{64'h7FFF_FFFF_FFFF_FFFF, 6'd63, 1'b1, 4'd12, 64'h0000_0000_0000_0000};
        vecs[8]  = '{64'h0123_4567_89AB_CDEF, 6'd13, 1'b0, 4'd15, 64'h0000_091A_2B3C_4D5E};
        vecs[11] = '{64'hAAAA_AAAA_AAAA_AAAA, 6'd8,  1'b0, 4'd4,  64'h00AA_AAAA_AAAA_AAAA};
`ifdef SHIFTRIGHT_ARITH_EN
        vecs[1]  = '{64'h8000_0000_0000_00F0, 6'd4,  1'b1, 4'd5,  64'hF800_0000_0000_000F};
        vecs[2]  = '{64'h8000_0000_0000_0001, 6'd63, 1'b1, 4'd7,  64'hFFFF_FFFF_FFFF_FFFF};
        vecs[6]  = '{64'hDEAD_BEEF_1234_5678, 6'd20, 1'b1, 4'd11, 64'hFFFF_FDEA_DBEE_F123};
        vecs[9]  = '{64'hFFFF_0000_FFFF_0000, 6'd48, 1'b1, 4'd1,  64'hFFFF_FFFF_FFFF_FFFF};
        vecs[10] = '{64'h8000_0000_0000_0000, 6'd1,  1'b1, 4'd2,  64'hC000_0000_0000_0000};
`else
        vecs[1]  = '{64'h8000_0000_0000_00F0, 6'd4,  1'b1, 4'd5,  64'h0800_0000_0000_000F};
        vecs[2]  = '{64'h8000_0000_0000_0001, 6'd63, 1'b1, 4'd7,  64'h0000_0000_0000_0001};
        vecs[6]  = '{64'hDEAD_BEEF_1234_5678, 6'd20, 1'b1, 4'd11, 64'h0000_0DEA_DBEE_F123};
        vecs[9]  = '{64'hFFFF_0000_FFFF_0000, 6'd48, 1'b1, 4'd1,  64'h0000_0000_0000_FFFF};
        vecs[10] = '{64'h8000_0000_0000_0000, 6'd1,  1'b1, 4'd2,  64'h4000_0000_0000_0000};
`endif

        // Reset values, then release
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        applyStimulus(64'h0, 6'd0, 1'b0, 4'd0, 1'b0);
        #2;
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_lsr", lsr, 64'd0);
        checkOutput("reset_out_tag", 64'(out_tag), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);

        // Directed vectors
        for (int i = 0; i < 12; i++) runVector(i);

        // Backpressure: tags 0..5 streamed while out_ready is held low
        base = retired;
        idx  = 0;
        for (int cyc = 0; cyc < 60 && (retired - base) < 6; cyc++) begin
            out_ready = (cyc >= 7);
            applyStimulus({16'h1234, 16'hF00D, 24'h0, 2'b10, 6'(idx)} ^ 64'h8000_0000_0000_0000,
                          6'(idx * 7 + 3), 1'b1, 4'(idx), (idx < 6));
            #1;
            if (cyc == 2) checkOutput("bp_ready_bubble", 64'(in_ready), 64'd1);
            if (cyc >= 3 && cyc <= 6) begin
                checkOutput($sformatf("bp_ready_full_c%0d", cyc), 64'(in_ready), 64'd0);
                checkOutput($sformatf("bp_out_valid_c%0d", cyc), 64'(out_valid), 64'd1);
                if (sb.size() != 0) begin
                    checkOutput($sformatf("bp_lsr_stable_c%0d", cyc), lsr, sb[0].data);
                    checkOutput($sformatf("bp_tag_stable_c%0d", cyc), 64'(out_tag), 64'(sb[0].tag));
                end
            end
            if (cyc == 7) checkOutput("bp_ready_retire", 64'(in_ready), 64'd1);
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) idx++;
            #1;
        end
        in_valid = 1'b0;
        checkOutput("bp_all_retired", 64'(retired - base), 64'd6);

        // Flush with two operations in flight and a third presented
        out_ready = 1'b1;
        repeat (3) waitCycle();
        applyStimulus(64'hFFFF_FFFF_0000_0000, 6'd5, 1'b1, 4'd1, 1'b1);
        waitCycle();
        applyStimulus(64'h0F0F_0F0F_0F0F_0F0F, 6'd9, 1'b0, 4'd2, 1'b1);
        waitCycle();
        applyStimulus(64'h1111_2222_3333_4444, 6'd1, 1'b0, 4'd3, 1'b1);
        flush = 1'b1;
        #1;
        checkOutput("flush_in_ready", 64'(in_ready), 64'd0);
        waitCycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        checkOutput("flush_busy", 64'(busy), 64'd0);
        seen = 0;
        repeat (5) begin
            if (out_valid) seen++;
            waitCycle();
        end
        checkOutput("flush_no_output", 64'(seen), 64'd0);

        // Asynchronous reset with three operations in flight
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(64'hC000_0000_0000_0000 >> k, 6'(k + 2), 1'b1, 4'(k + 6), 1'b1);
            waitCycle();
        end
        in_valid = 1'b0;
        checkOutput("rst_pre_out_valid", 64'(out_valid), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_lsr", lsr, 64'd0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        seen = 0;
        repeat (5) begin
            if (out_valid) seen++;
            waitCycle();
        end
        checkOutput("rst_no_stale", 64'(seen), 64'd0);

        // Randomized traffic against the scoreboard
        for (int c = 0; c < 600; c++) begin
            applyStimulus({$urandom, $urandom}, 6'($urandom_range(0, 63)),
                          1'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            waitCycle();
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            waitCycle();
            n++;
        end
        checkOutput("drain_empty", 64'(sb.size()), 64'd0);
        waitCycle();
        checkOutput("drain_busy", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
